// File: rtl/lookup_arbiter.sv
`default_nettype none
//------------------------------------------------------------------------------
// lookup_arbiter : round-robin arbiter that hands one RX port's MAC pair at a
//                  time to the lookup/learn engine and tracks completion.
// Revision       : 1.0
//------------------------------------------------------------------------------
module lookup_arbiter #(
  parameter int NUM_PORTS      = 4,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                              switch_clk,
  input  logic                              switch_rst_n,
  input  logic [NUM_PORTS-1:0]              req_valid_i,
  input  logic [NUM_PORTS-1:0][47:0]        req_dst_mac_i,
  input  logic [NUM_PORTS-1:0][47:0]        req_src_mac_i,
  output logic [NUM_PORTS-1:0]              req_ready_o,
  output logic                              lu_valid_o,
  output logic [47:0]                       lu_dst_mac_o,
  output logic [47:0]                       lu_src_mac_o,
  output logic [$clog2(NUM_PORTS)-1:0]      lu_port_o,
  input  logic                              lu_ready_i,
  input  logic                              lu_done_i,
  output logic [NUM_PORTS-1:0]              grant_o,
  output logic                              lu_timeout_o
);

  localparam int                   PW         = $clog2(NUM_PORTS);
  localparam int                   CW         = $clog2(TIMEOUT_CYCLES);
  localparam logic [CW-1:0]        C_CNT_LAST = CW'(TIMEOUT_CYCLES - 1);
  localparam logic [NUM_PORTS-1:0] C_ONE      = NUM_PORTS'(1);

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_ISSUE     = 2'd1,
    ST_WAIT_DONE = 2'd2
  } state_t;

  state_t              r_state;
  logic [PW-1:0]       r_last_grant;
  logic [CW-1:0]       r_cnt;

  logic                w_any;
  logic [PW-1:0]       w_sel;
  logic [NUM_PORTS-1:0] w_sel_oh;

  // Two passes: lowest requester above last_grant wins, otherwise wrap to the lowest overall.
  always_comb begin
    w_any = 1'b0;
    w_sel = '0;
    for (int i = NUM_PORTS - 1; i >= 0; i--) begin
      if (req_valid_i[i] && (PW'(i) > r_last_grant)) begin
        w_any = 1'b1;
        w_sel = PW'(i);
      end
    end
    if (!w_any) begin
      for (int i = NUM_PORTS - 1; i >= 0; i--) begin
        if (req_valid_i[i]) begin
          w_any = 1'b1;
          w_sel = PW'(i);
        end
      end
    end
  end

  assign w_sel_oh    = C_ONE << w_sel;
  assign req_ready_o = (switch_rst_n && (r_state == ST_IDLE) && w_any) ? w_sel_oh : '0;

  always_ff @(posedge switch_clk or negedge switch_rst_n) begin
    if (!switch_rst_n) begin
      r_state      <= ST_IDLE;
      r_last_grant <= PW'(NUM_PORTS - 1);
      r_cnt        <= '0;
      lu_valid_o   <= 1'b0;
      lu_timeout_o <= 1'b0;
      grant_o      <= '0;
      lu_dst_mac_o <= '0;
      lu_src_mac_o <= '0;
      lu_port_o    <= '0;
    end else begin
      lu_timeout_o <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_any) begin
            lu_dst_mac_o <= req_dst_mac_i[w_sel];
            lu_src_mac_o <= req_src_mac_i[w_sel];
            lu_port_o    <= w_sel;
            r_last_grant <= w_sel;
            grant_o      <= w_sel_oh;
            lu_valid_o   <= 1'b1;
            r_state      <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          if (lu_ready_i) begin
            lu_valid_o <= 1'b0;
            r_cnt      <= '0;
            r_state    <= ST_WAIT_DONE;
          end
        end
        ST_WAIT_DONE: begin
          // Completion takes precedence over a coincident timeout.
          if (lu_done_i) begin
            grant_o <= '0;
            r_state <= ST_IDLE;
          end else if (r_cnt == C_CNT_LAST) begin
            grant_o      <= '0;
            lu_timeout_o <= 1'b1;
            r_state      <= ST_IDLE;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: begin
          grant_o    <= '0;
          lu_valid_o <= 1'b0;
          r_state    <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_lookup_arbiter.sv
`default_nettype none
//------------------------------------------------------------------------------
// tb_lookup_arbiter : directed scenarios plus random traffic against a
//                     transaction-level reference model.
// Revision          : 1.0
//------------------------------------------------------------------------------
module tb_lookup_arbiter;

  localparam int N  = 4;
  localparam int T  = 64;
  localparam int PW = 2;

  logic                 switch_clk = 1'b0;
  logic                 switch_rst_n;
  logic [N-1:0]         req_valid_i;
  logic [N-1:0][47:0]   req_dst_mac_i;
  logic [N-1:0][47:0]   req_src_mac_i;
  logic [N-1:0]         req_ready_o;
  logic                 lu_valid_o;
  logic [47:0]          lu_dst_mac_o;
  logic [47:0]          lu_src_mac_o;
  logic [PW-1:0]        lu_port_o;
  logic                 lu_ready_i;
  logic                 lu_done_i;
  logic [N-1:0]         grant_o;
  logic                 lu_timeout_o;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: owner of the engine (-1 = free), whether it was handed over,
  // how many cycles it has been waiting, and what was last captured.
  int          m_owner;
  bit          m_issued;
  int          m_wait;
  int          m_last;
  int          m_port;
  logic [47:0] m_dst;
  logic [47:0] m_src;
  bit          m_tmo;
  bit          m_in_rst;
  bit          g_fixed;
  bit          prev_valid;
  int          obs_grants[$];

  lookup_arbiter #(.NUM_PORTS(N), .TIMEOUT_CYCLES(T)) dut (
    .switch_clk    (switch_clk),
    .switch_rst_n  (switch_rst_n),
    .req_valid_i   (req_valid_i),
    .req_dst_mac_i (req_dst_mac_i),
    .req_src_mac_i (req_src_mac_i),
    .req_ready_o   (req_ready_o),
    .lu_valid_o    (lu_valid_o),
    .lu_dst_mac_o  (lu_dst_mac_o),
    .lu_src_mac_o  (lu_src_mac_o),
    .lu_port_o     (lu_port_o),
    .lu_ready_i    (lu_ready_i),
    .lu_done_i     (lu_done_i),
    .grant_o       (grant_o),
    .lu_timeout_o  (lu_timeout_o)
  );

  always #5 switch_clk = ~switch_clk;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  function automatic int pick();
    int p;
    if (m_in_rst || m_owner != -1) return -1;
    for (int k = 1; k <= N; k++) begin
      p = (m_last + k) % N;
      if (req_valid_i[p[PW-1:0]]) return p;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_owner  = -1;
    m_issued = 1'b0;
    m_wait   = 0;
    m_last   = N - 1;
    m_port   = 0;
    m_dst    = '0;
    m_src    = '0;
    m_tmo    = 1'b0;
  endtask

  task automatic check_outputs();
    int           s;
    logic [N-1:0] er;
    logic [N-1:0] eg;
    s  = pick();
    er = (s >= 0) ? (N'(1) << s) : '0;
    eg = (m_owner >= 0) ? (N'(1) << m_owner) : '0;
    chk("req_ready", req_ready_o, er);
    chk("lu_valid", lu_valid_o, (m_owner >= 0) && !m_issued);
    chk("grant", grant_o, eg);
    chk("lu_timeout", lu_timeout_o, m_tmo);
    chk("lu_port", lu_port_o, m_port);
    chk("lu_dst", lu_dst_mac_o, m_dst);
    chk("lu_src", lu_src_mac_o, m_src);
    if (lu_valid_o && !prev_valid) obs_grants.push_back(int'(lu_port_o));
    prev_valid = lu_valid_o;
  endtask

  task automatic model_step();
    int s;
    s     = pick();
    m_tmo = 1'b0;
    if (m_owner < 0) begin
      if (s >= 0) begin
        m_owner  = s;
        m_issued = 1'b0;
        m_last   = s;
        m_port   = s;
        m_dst    = req_dst_mac_i[s[PW-1:0]];
        m_src    = req_src_mac_i[s[PW-1:0]];
      end
    end else if (!m_issued) begin
      if (lu_ready_i) begin
        m_issued = 1'b1;
        m_wait   = 0;
      end
    end else begin
      if (lu_done_i) begin
        m_owner = -1;
      end else if (m_wait + 1 == T) begin
        m_owner = -1;
        m_tmo   = 1'b1;
      end else begin
        m_wait++;
      end
    end
  endtask

  task automatic cycle(input logic [N-1:0] v, input bit rdy, input bit done);
    @(negedge switch_clk);
    req_valid_i = v;
    lu_ready_i  = rdy;
    lu_done_i   = done;
    if (!g_fixed) begin
      for (int p = 0; p < N; p++) begin
        req_dst_mac_i[p] = {16'($urandom), $urandom};
        req_src_mac_i[p] = {16'($urandom), $urandom};
      end
    end
    #1;
    check_outputs();
    model_step();
  endtask

  task automatic do_reset();
    @(negedge switch_clk);
    #2;
    switch_rst_n = 1'b0;
    m_in_rst     = 1'b1;
    model_reset();
    #1;
    check_outputs();
    @(posedge switch_clk);
    #1;
    check_outputs();
    @(negedge switch_clk);
    switch_rst_n = 1'b1;
    m_in_rst     = 1'b0;
    prev_valid   = 1'b0;
    #1;
    check_outputs();
    model_step();
  endtask

  task automatic drain();
    repeat (3) cycle('0, 1'b1, 1'b1);
  endtask

  initial begin
    int lat;
    logic [N-1:0] v;
    switch_rst_n  = 1'b0;
    req_valid_i   = '0;
    req_dst_mac_i = '0;
    req_src_mac_i = '0;
    lu_ready_i    = 1'b0;
    lu_done_i     = 1'b0;
    g_fixed       = 1'b0;
    prev_valid    = 1'b0;
    m_in_rst      = 1'b1;
    model_reset();
    do_reset();

    // Single request from port 2
    g_fixed          = 1'b1;
    req_dst_mac_i    = '0;
    req_src_mac_i    = '0;
    req_dst_mac_i[2] = 48'hAABB_CCDD_EE00;
    req_src_mac_i[2] = 48'h1234_5678_9A00;
    cycle(4'b0100, 1'b1, 1'b0);
    chk("single_ready", req_ready_o, 4'b0100);
    cycle(4'b0000, 1'b1, 1'b0);
    chk("single_valid", lu_valid_o, 1'b1);
    chk("single_port", lu_port_o, 2'd2);
    chk("single_dst", lu_dst_mac_o, 48'hAABB_CCDD_EE00);
    chk("single_src", lu_src_mac_o, 48'h1234_5678_9A00);
    repeat (4) cycle(4'b0000, 1'b1, 1'b0);
    chk("single_valid_once", lu_valid_o, 1'b0);
    cycle(4'b0000, 1'b1, 1'b1);
    cycle(4'b0000, 1'b1, 1'b0);
    chk("single_idle_grant", grant_o, 4'b0000);
    chk("single_no_timeout", lu_timeout_o, 1'b0);
    g_fixed = 1'b0;

    // All ports continuously requesting, engine done immediately
    do_reset();
    obs_grants.delete();
    repeat (30) cycle(4'b1111, 1'b1, 1'b1);
    if (obs_grants.size() < 8) chk("rr_grant_count", obs_grants.size(), 8);
    else for (int i = 0; i < 8; i++) chk("rr_order", obs_grants[i], i % N);

    // Backpressure on the engine side
    drain();
    g_fixed          = 1'b1;
    req_dst_mac_i[1] = 48'h0102_0304_0506;
    req_src_mac_i[1] = 48'h0A0B_0C0D_0E0F;
    cycle(4'b0010, 1'b0, 1'b0);
    chk("bp_ready", req_ready_o, 4'b0010);
    for (int i = 0; i < 10; i++) begin
      cycle(4'b0010, 1'b0, 1'b0);
      chk("bp_valid", lu_valid_o, 1'b1);
      chk("bp_dst_stable", lu_dst_mac_o, 48'h0102_0304_0506);
      chk("bp_ready_zero", req_ready_o, 4'b0000);
    end
    drain();
    g_fixed = 1'b0;

    // Timeout, then done on the last possible cycle
    do_reset();
    cycle(4'b1010, 1'b1, 1'b0);
    cycle(4'b1010, 1'b1, 1'b0);
    lat = 999;
    for (int i = 0; i < 200; i++) begin
      cycle(4'b1010, 1'b1, 1'b0);
      if (lu_timeout_o) begin
        lat = i;
        break;
      end
    end
    chk("timeout_latency", lat, T);
    chk("timeout_next_ready", req_ready_o, 4'b1000);
    cycle(4'b1010, 1'b1, 1'b0);
    for (int i = 0; i < T - 1; i++) cycle(4'b1010, 1'b1, 1'b0);
    cycle(4'b1010, 1'b1, 1'b1);
    cycle(4'b1010, 1'b1, 1'b0);
    chk("done_wins_no_timeout", lu_timeout_o, 1'b0);
    chk("done_wins_idle", grant_o, 4'b0000);

    // Reset in WAIT_DONE with port 1 owning and ports 1,3 pending
    cycle(4'b1010, 1'b1, 1'b0);
    cycle(4'b1010, 1'b1, 1'b0);
    cycle(4'b1010, 1'b1, 1'b0);
    chk("pre_reset_grant", grant_o, 4'b0010);
    do_reset();
    chk("reset_first_grant", req_ready_o, 4'b0010);
    drain();

    // Spurious done in IDLE and ISSUE
    cycle(4'b0000, 1'b0, 1'b1);
    chk("spur_idle_grant", grant_o, 4'b0000);
    cycle(4'b0100, 1'b0, 1'b1);
    cycle(4'b0000, 1'b0, 1'b1);
    chk("spur_issue_valid", lu_valid_o, 1'b1);
    cycle(4'b0000, 1'b0, 1'b1);
    chk("spur_issue_hold", grant_o, 4'b0100);
    drain();

    // Random traffic, with windows where the engine never completes
    for (int i = 0; i < 4000; i++) begin
      v = N'($urandom);
      cycle(v, ($urandom % 4) != 0, ((i % 1000) < 600) ? (($urandom % 5) == 0) : 1'b0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
